// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared state encoding and constants for the MIPS
// instruction-fetch front end (mips_fetch_unit and its FIFO).
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/mips_fetch_fifo.sv
// mips_fetch_fifo: small synchronous FIFO used both as the prefetch
// buffer ({pc, data}) and as the pc-tag queue for in-flight requests.
// Clear has priority over push/pop; push on a full FIFO is accepted
// when a pop happens in the same cycle.
module mips_fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: pipelined instruction-fetch front end. Issues word
// requests to a variable-latency instruction memory under a credit rule,
// buffers responses in a prefetch FIFO and hands them to decode over a
// valid/ready handshake. Redirects clear the buffer and drop stale
// in-flight responses.
// Optional macro IFETCH_BYPASS_EN: a response arriving while the buffer
// is empty is presented to decode in the same cycle.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    localparam int              CW            = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     CREDIT_LIMIT  = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP       = XLEN'(WORD_BYTES);
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~XLEN'(WORD_BYTES - 1);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]     w_inflight;
    logic [CW-1:0]     w_data_count;
    logic              w_tag_full;
    logic              w_tag_empty;
    logic              w_data_full;
    logic              w_data_empty;
    logic [XLEN-1:0]   w_tag_pc;
    logic [2*XLEN-1:0] w_head;
    logic              w_credit_ok;
    logic              w_req_fire;
    logic              w_rsp_keep;
    logic              w_bypass;
    logic              w_data_push;
    logic              w_data_pop;
    logic [CW-1:0]     w_redirect_drop;
    fetch_state_e      w_resume_state;

    // A request is only issued if a buffer slot is already reserved for it.
    assign w_credit_ok = !w_tag_full && !w_data_full &&
                         (({1'b0, w_inflight} + {1'b0, w_data_count}) < CREDIT_LIMIT);

    assign imem_req_valid = (r_state == FETCH) && fetch_en && !redirect_valid && w_credit_ok;
    assign imem_addr      = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_keep      = imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0);
    assign w_redirect_drop = w_inflight - CW'(imem_rsp_valid);
    assign w_resume_state  = fetch_en ? FETCH : IDLE;

`ifdef IFETCH_BYPASS_EN
    assign w_bypass = w_data_empty && w_rsp_keep;
`else
    assign w_bypass = 1'b0;
`endif

    assign inst_valid  = !w_data_empty || w_bypass;
    assign w_data_pop  = inst_ready && !w_data_empty;
    assign w_data_push = w_rsp_keep && !(w_bypass && inst_ready);
    assign busy        = !w_tag_empty || (r_state != IDLE);

    // Present the buffer head, or the live response when it bypasses the buffer.
    always_comb begin
        inst_data = '0;
        inst_pc   = '0;
        if (!w_data_empty) begin
            inst_pc   = w_head[2*XLEN-1:XLEN];
            inst_data = w_head[XLEN-1:0];
        end else if (w_bypass) begin
            inst_pc   = w_tag_pc;
            inst_data = imem_rsp_data;
        end
    end

    // Fetch control: PC advance, redirect handling and the IDLE/FETCH/FLUSH machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc & PC_ALIGN_MASK;
            r_drop_cnt <= w_redirect_drop;
            if (w_redirect_drop != '0) begin
                r_state <= FLUSH;
            end else begin
                r_state <= w_resume_state;
            end
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            case (r_state)
                IDLE: begin
                    if (fetch_en) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (!fetch_en) begin
                        r_state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (r_drop_cnt == '0) begin
                        r_state <= w_resume_state;
                    end else if (imem_rsp_valid) begin
                        r_drop_cnt <= r_drop_cnt - CW'(1);
                        if (r_drop_cnt == CW'(1)) begin
                            r_state <= w_resume_state;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mips_fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_data_push),
        .i_pop   (w_data_pop),
        .i_clear (redirect_valid),
        .i_wdata ({w_tag_pc, imem_rsp_data}),
        .o_rdata (w_head),
        .o_count (w_data_count),
        .o_full  (w_data_full),
        .o_empty (w_data_empty)
    );

    mips_fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_fire),
        .i_pop   (imem_rsp_valid),
        .i_clear (1'b0),
        .i_wdata (r_fetch_pc),
        .o_rdata (w_tag_pc),
        .o_count (w_inflight),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed bench for mips_fetch_unit with a
// variable-latency memory model and an in-order scoreboard of expected
// instruction addresses.
module tb_mips_fetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        fetch_en       = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'hDEAD_0000;
    logic        inst_ready     = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;

    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int          acceptCount    = 0;
    int          respCount      = 0;
    int          deliveredCount = 0;
    int          cycleCnt       = 0;
    int          memLatency     = 1;
    logic [31:0] modelPc        = 32'h0;
    logic [31:0] lastPc         = 32'h0;
    logic [31:0] monExpPc       = 32'h0;
    logic        handshakeAtRedirect = 1'b0;
    logic [31:0] expQ[$];
    pend_t       pend[$];

    mips_fetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Contents of instruction memory: word at 0x4 reads back as 0x8C020004.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'h8C02_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic fen, input logic reqRdy, input logic instRdy,
                                 input logic redir, input logic [31:0] rpc);
        fetch_en       = fen;
        imem_req_ready = reqRdy;
        inst_ready     = instRdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    task automatic drain();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 200 && (busy || inst_valid || pend.size() != 0); i++) begin
            stepCycles(1);
        end
        checkOutput("drainIdle", {busy, inst_valid}, 2'b00);
    endtask

    // Memory model: responses in order, each no earlier than its due cycle.
    always begin
        @(posedge clk);
        #1;
        cycleCnt++;
        if (!rst_n) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_0000;
        end else begin
            if (imem_rsp_valid && pend.size() != 0) begin
                void'(pend.pop_front());
            end
            if (pend.size() != 0 && pend[0].due <= cycleCnt) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memWord(pend[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_0000;
            end
        end
    end

    // Monitor: scoreboard checks on delivered instructions and issued addresses.
    always begin
        @(negedge clk);
        if (rst_n) begin
            if (imem_rsp_valid) begin
                respCount++;
            end
            if (inst_valid && inst_ready) begin
                deliveredCount++;
                lastPc   = inst_pc;
                monExpPc = 32'hFFFF_FFFC;
                if (expQ.size() != 0) begin
                    monExpPc = expQ.pop_front();
                end
                checkOutput("instPc", inst_pc, monExpPc);
                checkOutput("instData", inst_data, memWord(monExpPc));
            end
            if (redirect_valid) begin
                handshakeAtRedirect = inst_valid && inst_ready;
                checkOutput("reqValidInRedirect", imem_req_valid, 1'b0);
                expQ.delete();
                modelPc = {redirect_pc[31:2], 2'b00};
            end
            if (imem_req_valid && imem_req_ready) begin
                acceptCount++;
                checkOutput("reqAddr", imem_addr, modelPc);
                expQ.push_back(modelPc);
                pend.push_back('{addr: imem_addr, due: cycleCnt + memLatency});
                modelPc = modelPc + 32'd4;
            end
        end
    end

    initial begin
        int base;
        int respBase;
        int delBase;

        // Reset state
        stepCycles(3);
        checkOutput("rstReqValid", imem_req_valid, 1'b0);
        checkOutput("rstAddr", imem_addr, 32'h0);
        checkOutput("rstInstValid", inst_valid, 1'b0);
        checkOutput("rstInstData", inst_data, 32'h0);
        checkOutput("rstInstPc", inst_pc, 32'h0);
        checkOutput("rstBusy", busy, 1'b0);
        rst_n = 1'b1;
        stepCycles(1);

        // Streaming with 1-cycle memory: one request and one delivery per cycle
        memLatency = 1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        stepCycles(5);
        base    = acceptCount;
        delBase = deliveredCount;
        stepCycles(10);
        checkOutput("streamAccepts", acceptCount - base, 10);
        checkOutput("streamDelivered", deliveredCount - delBase, 10);

        // Decode stalled: exactly DEPTH requests, then credit exhausted
        drain();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        base = acceptCount;
        stepCycles(15);
        checkOutput("fullAccepts", acceptCount - base, DEPTH);
        checkOutput("fullReqValid", imem_req_valid, 1'b0);
        checkOutput("fullInstValid", inst_valid, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        stepCycles(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        stepCycles(10);
        checkOutput("refillAccepts", acceptCount - base, DEPTH + 1);

        // Redirect with three requests in flight
        drain();
        memLatency = 8;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        base = acceptCount;
        for (int i = 0; i < 20 && (acceptCount - base) < 3; i++) begin
            stepCycles(1);
        end
        checkOutput("threeInFlight", acceptCount - base, 3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102);
        respBase = respCount;
        delBase  = deliveredCount;
        base     = acceptCount;
        stepCycles(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("flushInstValid", inst_valid, 1'b0);
        checkOutput("flushBusy", busy, 1'b1);
        checkOutput("flushReqValid", imem_req_valid, 1'b0);
        for (int i = 0; i < 50 && acceptCount == base; i++) begin
            stepCycles(1);
        end
        checkOutput("staleDropped", respCount - respBase, 3);
        for (int i = 0; i < 60 && deliveredCount == delBase; i++) begin
            stepCycles(1);
        end
        checkOutput("firstPcAfterRedirect", lastPc, 32'h0000_0100);

        // Redirect colliding with a response and a decode handshake
        memLatency = 2;
        stepCycles(25);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        stepCycles(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("handshakeInRedirect", handshakeAtRedirect, 1'b1);
        checkOutput("collideInstValid", inst_valid, 1'b0);
        checkOutput("collideReqValid", imem_req_valid, 1'b0);
        stepCycles(1);
        checkOutput("collideResumeValid", imem_req_valid, 1'b1);
        checkOutput("collideResumeAddr", imem_addr, 32'h0000_0200);

        // Memory not ready: address and valid held, PC does not advance
        drain();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0008);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        stepCycles(1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("holdValid", imem_req_valid, 1'b1);
            checkOutput("holdAddr", imem_addr, 32'h0000_0008);
            stepCycles(1);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        stepCycles(1);
        checkOutput("advanceAddr", imem_addr, 32'h0000_000C);

        // Response-to-decode latency from an empty buffer
        drain();
        memLatency = 1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0004);
        stepCycles(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 20 && !imem_rsp_valid; i++) begin
            stepCycles(1);
        end
        checkOutput("latRspSeen", imem_rsp_valid, 1'b1);
`ifdef IFETCH_BYPASS_EN
        checkOutput("latInstValid", inst_valid, 1'b1);
        checkOutput("latInstData", inst_data, 32'h8C02_0004);
        checkOutput("latInstPc", inst_pc, 32'h0000_0004);
`else
        checkOutput("latInstValidEarly", inst_valid, 1'b0);
        stepCycles(1);
        checkOutput("latInstValid", inst_valid, 1'b1);
        checkOutput("latInstData", inst_data, 32'h8C02_0004);
        checkOutput("latInstPc", inst_pc, 32'h0000_0004);
`endif

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
